// File: rtl/row_col_dram_pkg.sv
// Shared sizing constants and address field helpers for the row/column DRAM model.
// The core modules take their widths as parameters that default to these values.
package row_col_dram_pkg;

  localparam int DATA_W   = 8;
  localparam int ROW_W    = 4;
  localparam int COL_W    = 4;
  localparam int ADDR_W   = ROW_W + COL_W;
  localparam int NUM_ROWS = 1 << ROW_W;
  localparam int NUM_COLS = 1 << COL_W;

  // The row field sits in the upper bits of the address, the column in the lower bits.
  function automatic logic [ROW_W-1:0] row_of(input logic [ADDR_W-1:0] addr);
    return addr[ADDR_W-1:COL_W];
  endfunction

  function automatic logic [COL_W-1:0] col_of(input logic [ADDR_W-1:0] addr);
    return addr[COL_W-1:0];
  endfunction

endpackage

// File: rtl/dram_addr_decoder.sv
// Splits a flat cell address into one-hot row and column select lines.
// Purely combinational; the caller registers whatever it needs.
module dram_addr_decoder
  import row_col_dram_pkg::*;
#(
  parameter int ROW_W = row_col_dram_pkg::ROW_W,
  parameter int COL_W = row_col_dram_pkg::COL_W
) (
  input  logic [ROW_W+COL_W-1:0] addr_i,
  output logic [(1<<ROW_W)-1:0]  row_sel_o,
  output logic [(1<<COL_W)-1:0]  col_sel_o
);

  localparam int A_W    = ROW_W + COL_W;
  localparam int N_ROWS = 1 << ROW_W;
  localparam int N_COLS = 1 << COL_W;

  logic [ROW_W-1:0] row_idx;
  logic [COL_W-1:0] col_idx;

  assign row_idx = addr_i[A_W-1:COL_W];
  assign col_idx = addr_i[COL_W-1:0];

  always_comb begin
    row_sel_o = '0;
    col_sel_o = '0;
    row_sel_o[row_idx] = 1'b1;
    col_sel_o[col_idx] = 1'b1;
  end

endmodule

// File: rtl/row_col_dram.sv
// Row/column organised cell array with one-hot select, gated writes and a
// registered read port. Reset clears every cell and the read register.
module row_col_dram
  import row_col_dram_pkg::*;
#(
  parameter int DATA_W = row_col_dram_pkg::DATA_W,
  parameter int ROW_W  = row_col_dram_pkg::ROW_W,
  parameter int COL_W  = row_col_dram_pkg::COL_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [ROW_W+COL_W-1:0] addr,
  input  logic [DATA_W-1:0]      wdata,
  input  logic                   write_en,
  output logic [DATA_W-1:0]      rdata
);

  localparam int N_ROWS = 1 << ROW_W;
  localparam int N_COLS = 1 << COL_W;

  logic [N_ROWS-1:0] row_sel;
  logic [N_COLS-1:0] col_sel;

  logic [DATA_W-1:0] cells_q [N_ROWS][N_COLS];
  logic [DATA_W-1:0] rd_mux;
  logic [DATA_W-1:0] rdata_q;
  logic [DATA_W-1:0] rdata_d;

  dram_addr_decoder #(
    .ROW_W (ROW_W),
    .COL_W (COL_W)
  ) u_dec (
    .addr_i    (addr),
    .row_sel_o (row_sel),
    .col_sel_o (col_sel)
  );

  // A cell is written only where its row line and column line coincide.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < N_ROWS; r++) begin
        for (int c = 0; c < N_COLS; c++) begin
          cells_q[r][c] <= '0;
        end
      end
    end else if (write_en) begin
      for (int r = 0; r < N_ROWS; r++) begin
        for (int c = 0; c < N_COLS; c++) begin
          if (row_sel[r] && col_sel[c]) begin
            cells_q[r][c] <= wdata;
          end
        end
      end
    end
  end

  // AND-OR read mux; exactly one cell matches the one-hot selects.
  always_comb begin
    rd_mux = '0;
    for (int r = 0; r < N_ROWS; r++) begin
      for (int c = 0; c < N_COLS; c++) begin
        if (row_sel[r] && col_sel[c]) begin
          rd_mux = rd_mux | cells_q[r][c];
        end
      end
    end
  end

  // Write cycles leave the read register untouched (no write-through).
  assign rdata_d = write_en ? rdata_q : rd_mux;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata = rdata_q;

endmodule

// File: tb/tb_row_col_dram.sv
// Directed bench for row_col_dram: reset behaviour, full-array walk, aliasing,
// write-cycle hold, mid-cycle reset and address boundary cells.
module tb_row_col_dram;

  logic       clk;
  logic       rst;
  logic [7:0] addr;
  logic [7:0] wdata;
  logic       write_en;
  logic [7:0] rdata;

  int errors = 0;
  int checks = 0;

  row_col_dram dut (
    .clk      (clk),
    .rst      (rst),
    .addr     (addr),
    .wdata    (wdata),
    .write_en (write_en),
    .rdata    (rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%02h expected=0x%02h", tag, obs, exp);
    end
  endtask

  task automatic do_write(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    addr = a; wdata = d; write_en = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic do_read(input logic [7:0] a);
    @(negedge clk);
    addr = a; wdata = 8'hC3; write_en = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; addr = 8'h00; wdata = 8'h00; write_en = 1'b0;
    #1;
    check("reset_rdata", rdata, 8'h00);

    // Write attempted while reset is held must be ignored.
    @(negedge clk);
    addr = 8'h12; wdata = 8'hEE; write_en = 1'b1;
    @(posedge clk);
    #1;
    check("reset_hold_rdata", rdata, 8'h00);
    @(negedge clk);
    rst = 1'b0; write_en = 1'b0;

    do_read(8'h12); check("write_during_reset_ignored", rdata, 8'h00);
    do_read(8'h00); check("post_reset_0x00", rdata, 8'h00);
    do_read(8'h5A); check("post_reset_0x5A", rdata, 8'h00);
    do_read(8'hFF); check("post_reset_0xFF", rdata, 8'h00);

    // Full walk: every cell holds row+col.
    for (int i = 0; i < 256; i++) begin
      do_write(8'(i), 8'((i >> 4) + (i & 15)));
    end
    for (int i = 0; i < 256; i++) begin
      do_read(8'(i));
      check($sformatf("walk_0x%02h", i), rdata, 8'((i >> 4) + (i & 15)));
    end
    do_read(8'hFF); check("walk_0xFF_spot", rdata, 8'h1E);
    do_read(8'h3C); check("walk_0x3C_spot", rdata, 8'h0F);

    // Reset mid-sequence discards the array contents.
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midseq_reset_rdata", rdata, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    do_read(8'h3C); check("midseq_reset_0x3C", rdata, 8'h00);
    do_read(8'hFF); check("midseq_reset_0xFF", rdata, 8'h00);

    // Row/column swap aliasing.
    do_write(8'h12, 8'hAA);
    do_read(8'h12); check("read_after_write_0x12", rdata, 8'hAA);
    do_read(8'h21); check("no_alias_0x21", rdata, 8'h00);

    // rdata holds through a write cycle.
    do_write(8'h40, 8'h33);
    do_read(8'h40); check("setup_0x40", rdata, 8'h33);
    do_write(8'h41, 8'h77); check("hold_during_write", rdata, 8'h33);
    do_read(8'h41); check("read_0x41", rdata, 8'h77);

    // Boundary cells.
    do_write(8'h0F, 8'h01);
    do_write(8'hF0, 8'h02);
    do_read(8'h0F); check("boundary_0x0F", rdata, 8'h01);
    // Address changes between edges must not disturb the registered output.
    addr = 8'hF0;
    #2;
    check("addr_between_edges", rdata, 8'h01);
    do_read(8'hF0); check("boundary_0xF0", rdata, 8'h02);

    // Full-width data.
    do_write(8'h00, 8'hFF);
    do_read(8'h00); check("full_width_0x00", rdata, 8'hFF);

    // Reset pulse between edges.
    do_write(8'h80, 8'h55);
    do_read(8'h80); check("pre_pulse_0x80", rdata, 8'h55);
    #1;
    rst = 1'b1;
    #1;
    check("async_reset_rdata", rdata, 8'h00);
    #1;
    rst = 1'b0;
    do_read(8'h80); check("after_pulse_0x80", rdata, 8'h00);
    do_read(8'h0F); check("after_pulse_0x0F", rdata, 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
